// File: rtl/adder_tree_pkg.sv
// Shared types and sizes for the adder tree and its operand loader.
package adder_tree_pkg;

  localparam int unsigned ADDER_WIDTH  = 8;
  localparam int unsigned NUM_OPERANDS = 8;
  localparam int unsigned IDX_W        = $clog2(NUM_OPERANDS);
  localparam int unsigned FRAME_W      = NUM_OPERANDS * ADDER_WIDTH;

  typedef logic [ADDER_WIDTH-1:0] operand_t;
  typedef operand_t               frame_t [NUM_OPERANDS];
  typedef logic [IDX_W-1:0]       idx_t;
  typedef logic [IDX_W:0]         len_t;

  // Flatten a frame so slot k lands at bits [k*ADDER_WIDTH +: ADDER_WIDTH].
  function automatic logic [FRAME_W-1:0] pack_frame(input frame_t f);
    logic [FRAME_W-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      w[k*ADDER_WIDTH +: ADDER_WIDTH] = f[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/adder_tree_operand_loader_if.sv
// Operand stream in, parallel frame stream out.
interface adder_tree_operand_loader_if;
  import adder_tree_pkg::*;

  operand_t           in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [FRAME_W-1:0] frame_data;
  len_t               frame_len;
  logic               frame_valid;
  logic               frame_ready;

  // Producer of operands and consumer of frames.
  modport master (
    output in_data, in_valid, in_last, frame_ready,
    input  in_ready, frame_data, frame_len, frame_valid
  );

  // The loader itself.
  modport slave (
    input  in_data, in_valid, in_last, frame_ready,
    output in_ready, frame_data, frame_len, frame_valid
  );

endinterface

// File: rtl/adder_tree_operand_bank.sv
// NUM_OPERANDS x ADDER_WIDTH register array: whole-array load, clear, single-slot write.
module adder_tree_operand_bank
  import adder_tree_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clear_i,
  input  logic     wr_en_i,
  input  idx_t     wr_idx_i,
  input  operand_t wr_data_i,
  input  logic     load_en_i,
  input  frame_t   load_data_i,
  output frame_t   data_o
);

  frame_t mem_q;

  // Load wins over clear, clear wins over a slot write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OPERANDS; k++) mem_q[k] <= '0;
    end else if (load_en_i) begin
      mem_q <= load_data_i;
    end else if (clear_i) begin
      for (int k = 0; k < NUM_OPERANDS; k++) mem_q[k] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign data_o = mem_q;

endmodule

// File: rtl/adder_tree_operand_loader.sv
// Assembles a stream of operands into zero-padded, double-buffered frames for the adder tree.
module adder_tree_operand_loader
  import adder_tree_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  adder_tree_operand_loader_if.slave  bus
);

  localparam idx_t LastIdx = idx_t'(NUM_OPERANDS - 1);

  idx_t fill_idx_q, fill_idx_d;
  len_t fill_len_q, fill_len_d;
  logic fill_done_q, fill_done_d;
  logic out_valid_q, out_valid_d;
  len_t frame_len_q, frame_len_d;

  frame_t fill_buf;
  frame_t out_buf;
  frame_t zero_frame;

  logic accept;
  logic transfer;

  // in_ready depends on registered state only, so accept and transfer are mutually exclusive.
  assign accept   = bus.in_valid & ~fill_done_q;
  assign transfer = fill_done_q & (~out_valid_q | bus.frame_ready);

  assign zero_frame = '{default: '0};

  // Fill side: written slot by slot, cleared as its contents move to the output side.
  adder_tree_operand_bank u_fill_bank (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (transfer),
    .wr_en_i     (accept),
    .wr_idx_i    (fill_idx_q),
    .wr_data_i   (bus.in_data),
    .load_en_i   (1'b0),
    .load_data_i (zero_frame),
    .data_o      (fill_buf)
  );

  // Output side: loaded whole, held stable while downstream stalls.
  adder_tree_operand_bank u_out_bank (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (1'b0),
    .wr_en_i     (1'b0),
    .wr_idx_i    ('0),
    .wr_data_i   ('0),
    .load_en_i   (transfer),
    .load_data_i (fill_buf),
    .data_o      (out_buf)
  );

  // Next-state for fill index/length and the two buffer-full flags.
  always_comb begin
    fill_idx_d  = fill_idx_q;
    fill_len_d  = fill_len_q;
    fill_done_d = fill_done_q;
    out_valid_d = out_valid_q;
    frame_len_d = frame_len_q;

    if (accept) begin
      if (fill_idx_q == LastIdx || bus.in_last) begin
        fill_done_d = 1'b1;
        fill_len_d  = len_t'(fill_idx_q) + len_t'(1);
      end else begin
        fill_idx_d = fill_idx_q + idx_t'(1);
      end
    end

    if (transfer) begin
      frame_len_d = fill_len_q;
      out_valid_d = 1'b1;
      fill_done_d = 1'b0;
      fill_idx_d  = '0;
    end else if (out_valid_q && bus.frame_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_idx_q  <= '0;
      fill_len_q  <= '0;
      fill_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      frame_len_q <= '0;
    end else begin
      fill_idx_q  <= fill_idx_d;
      fill_len_q  <= fill_len_d;
      fill_done_q <= fill_done_d;
      out_valid_q <= out_valid_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign bus.in_ready    = ~fill_done_q;
  assign bus.frame_valid = out_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.frame_data  = pack_frame(out_buf);

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Directed checks for the operand loader: full/short frames, backpressure, streaming, reset.
module tb_adder_tree_operand_loader;
  import adder_tree_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  len;
  } cap_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  cap_t cap_q[$];

  adder_tree_operand_loader_if bus ();

  adder_tree_operand_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every frame that will be consumed at the coming posedge.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.frame_valid && bus.frame_ready) begin
      cap_q.push_back('{data: bus.frame_data, len: bus.frame_len});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] slot_sum(input logic [63:0] d);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + 64'(d[k*8 +: 8]);
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the operand is accepted.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.frame_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(bus.frame_valid), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_d;
    logic [63:0] exp_sum;
    int          n;

    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_valid", 64'(bus.frame_valid), 64'd0);
    check("rst_data", bus.frame_data, 64'd0);
    check("rst_len", 64'(bus.frame_len), 64'd0);

    // Full frame 0x01..0x08 with downstream always ready.
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    check("full_stall", 64'(bus.in_ready), 64'd0);
    check("full_not_yet", 64'(bus.frame_valid), 64'd0);
    @(negedge clk);
    check("full_valid", 64'(bus.frame_valid), 64'd1);
    check("full_data", bus.frame_data, 64'h0807060504030201);
    check("full_len", 64'(bus.frame_len), 64'd8);
    check("full_ready_back", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("full_consumed", 64'(bus.frame_valid), 64'd0);

    // Short frames: three operands, then a single one.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    check("short_stall", 64'(bus.in_ready), 64'd0);
    wait_valid("short_wait");
    check("short_data", bus.frame_data, 64'h0000000000CCBBAA);
    check("short_len", 64'(bus.frame_len), 64'd3);
    @(negedge clk);
    send(8'h7F, 1'b1);
    wait_valid("one_wait");
    check("one_data", bus.frame_data, 64'h000000000000007F);
    check("one_len", 64'(bus.frame_len), 64'd1);
    @(negedge clk);

    // Backpressure: A held while B fills, then B replaces A with no bubble.
    bus.frame_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    wait_valid("bp_a_wait");
    check("bp_a_data", bus.frame_data, 64'h0807060504030201);
    for (int i = 8'h11; i <= 8'h18; i++) send(8'(i), 1'b0);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_a_held", bus.frame_data, 64'h0807060504030201);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_data", bus.frame_data, 64'h0807060504030201);
      check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    check("bp_b_valid", 64'(bus.frame_valid), 64'd1);
    check("bp_b_data", bus.frame_data, 64'h1817161514131211);
    check("bp_b_len", 64'(bus.frame_len), 64'd8);
    check("bp_b_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("bp_b_held", bus.frame_data, 64'h1817161514131211);
    bus.frame_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Four frames with random input gaps; the monitor collects what leaves.
    cap_q.delete();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(8'(8'h20 + f * 8 + k), 1'b0);
      end
    end
    n = 0;
    while (cap_q.size() < 4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("stream_count", 64'(cap_q.size()), 64'd4);
    for (int f = 0; f < 4 && f < cap_q.size(); f++) begin
      exp_d   = '0;
      exp_sum = '0;
      for (int k = 0; k < 8; k++) begin
        exp_d[k*8 +: 8] = 8'(8'h20 + f * 8 + k);
        exp_sum         = exp_sum + 64'(8'h20 + f * 8 + k);
      end
      check("stream_data", cap_q[f].data, exp_d);
      check("stream_len", 64'(cap_q[f].len), 64'd8);
      check("stream_sum", slot_sum(cap_q[f].data), exp_sum);
    end

    // Asynchronous reset with a held frame and a partial fill in flight.
    bus.frame_ready = 1'b0;
    for (int i = 8'h31; i <= 8'h38; i++) send(8'(i), 1'b0);
    wait_valid("rst_pre_wait");
    for (int i = 8'h51; i <= 8'h55; i++) send(8'(i), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.frame_valid), 64'd0);
    check("arst_data", bus.frame_data, 64'd0);
    check("arst_len", 64'(bus.frame_len), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst             = 1'b0;
    bus.frame_ready = 1'b1;
    cap_q.delete();
    @(negedge clk);
    send(8'h61, 1'b0);
    send(8'h62, 1'b1);
    wait_valid("post_rst_wait");
    check("post_rst_data", bus.frame_data, 64'h0000000000006261);
    check("post_rst_len", 64'(bus.frame_len), 64'd2);
    @(negedge clk);

    // All-ones operands: widest sum the tree will see.
    for (int i = 0; i < 8; i++) send(8'hFF, 1'b0);
    wait_valid("max_wait");
    check("max_data", bus.frame_data, 64'hFFFFFFFFFFFFFFFF);
    check("max_len", 64'(bus.frame_len), 64'd8);
    check("max_sum", slot_sum(bus.frame_data), 64'h7F8);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_count", 64'(cap_q.size()), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
